// File: rtl/piso_fifo.sv
// rtl/piso_fifo.sv - wide-word FWFT input FIFO feeding a LS-slice-first serialiser onto a valid/ready stream
module piso_fifo #(
    parameter int DIN_WIDTH  = 256,
    parameter int DOUT_WIDTH = 64,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  din_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    localparam int R  = DIN_WIDTH / DOUT_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(R);

    logic [DIN_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DIN_WIDTH-1:0] word_q, word_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 dout_valid_q, dout_valid_d;

    logic full, empty, push, pop, transfer, last_slice;

    always_comb begin
        full       = (count_q == CW'(FIFO_DEPTH));
        empty      = (count_q == '0);
        push       = din_valid && !full;
        transfer   = dout_valid_q && dout_ready;
        last_slice = (idx_q == IW'(R - 1));
        pop        = (!dout_valid_q || (transfer && last_slice)) && !empty;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);

        // Final slice with nothing queued keeps idx, so dout holds its last value.
        word_d       = word_q;
        idx_d        = idx_q;
        dout_valid_d = dout_valid_q;
        if (pop) begin
            word_d       = mem[rd_ptr_q];
            idx_d        = '0;
            dout_valid_d = 1'b1;
        end else if (transfer) begin
            if (last_slice) begin
                dout_valid_d = 1'b0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            word_q       <= '0;
            idx_q        <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            word_q       <= word_d;
            idx_q        <= idx_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = word_q[idx_q*DOUT_WIDTH +: DOUT_WIDTH];
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_piso_fifo.sv
// tb/tb_piso_fifo.sv - directed vector table plus scoreboard sequences for piso_fifo
module tb_piso_fifo;

    logic         clk;
    logic         rst;
    logic [255:0] din;
    logic         din_valid;
    logic [63:0]  dout;
    logic         dout_valid;
    logic         dout_ready;

    int n_pass  = 0;
    int n_total = 0;

    logic [63:0] exp_q[$];

    piso_fifo #(
        .DIN_WIDTH (256),
        .DOUT_WIDTH(64),
        .FIFO_DEPTH(512)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    typedef struct {
        logic         rst;
        logic         din_valid;
        logic [255:0] din;
        logic         dout_ready;
        logic         exp_valid;
        logic         chk_dout;
        logic [63:0]  exp_dout;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic dv, input logic [255:0] d,
                                input logic rdy, input logic ev, input logic cd,
                                input logic [63:0] ed);
        vec_t v;
        v.rst = r; v.din_valid = dv; v.din = d; v.dout_ready = rdy;
        v.exp_valid = ev; v.chk_dout = cd; v.exp_dout = ed;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk_word(input int w);
        logic [255:0] r;
        for (int k = 0; k < 4; k++) r[k*64 +: 64] = {32'(w), 32'(k)};
        return r;
    endfunction

    task automatic expect_word(input logic [255:0] w);
        for (int k = 0; k < 4; k++) exp_q.push_back(w[k*64 +: 64]);
    endtask

    // mode 0: dout_ready always 1; mode 1: ready pattern 1,0,0 repeating
    task automatic drain(input int mode, input int max_cycles);
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic [63:0] held = '0;
        logic [63:0] e;
        while (exp_q.size() > 0 && cyc < max_cycles) begin
            dout_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            @(negedge clk);
            if (stalled) begin
                check("hold_valid", 64'(dout_valid), 64'd1);
                check("hold_dout", dout, held);
            end
            if (dout_valid && dout_ready) begin
                e = exp_q.pop_front();
                check("slice", dout, e);
                stalled = 1'b0;
            end else begin
                stalled = dout_valid;
                held    = dout;
            end
            tick();
            cyc++;
        end
        check("drain_complete_remaining", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
        check("drain_valid_low", 64'(dout_valid), 64'd0);
        tick();
    endtask

    logic [255:0] w1, wa, wb;

    initial begin
        rst = 1'b1; din_valid = 1'b0; din = '0; dout_ready = 1'b0;

        w1 = {64'h4, 64'h3, 64'h2, 64'h1};
        wa = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        wb = {64'hB3, 64'hB2, 64'hB1, 64'hB0};

        // reset held three cycles, then released idle
        add(1, 0, '0, 0, 0, 1, 64'h0);
        add(1, 0, '0, 0, 0, 1, 64'h0);
        add(1, 0, '0, 0, 0, 1, 64'h0);
        add(0, 0, '0, 0, 0, 1, 64'h0);
        add(0, 0, '0, 0, 0, 0, 64'h0);
        // single word: written at edge N, presented after N+1
        add(0, 1, w1, 1, 0, 0, 64'h0);
        add(0, 0, '0, 1, 1, 1, 64'h1);
        add(0, 0, '0, 1, 1, 1, 64'h2);
        add(0, 0, '0, 1, 1, 1, 64'h3);
        add(0, 0, '0, 1, 1, 1, 64'h4);
        add(0, 0, '0, 1, 0, 0, 64'h0);
        // back-to-back words, no bubble at the word boundary
        add(0, 1, wa, 1, 0, 0, 64'h0);
        add(0, 1, wb, 1, 1, 1, 64'hA0);
        add(0, 0, '0, 1, 1, 1, 64'hA1);
        add(0, 0, '0, 1, 1, 1, 64'hA2);
        add(0, 0, '0, 1, 1, 1, 64'hA3);
        add(0, 0, '0, 1, 1, 1, 64'hB0);
        add(0, 0, '0, 1, 1, 1, 64'hB1);
        add(0, 0, '0, 1, 1, 1, 64'hB2);
        add(0, 0, '0, 1, 1, 1, 64'hB3);
        add(0, 0, '0, 1, 0, 0, 64'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; din_valid = tbl[i].din_valid;
            din = tbl[i].din; dout_ready = tbl[i].dout_ready;
            tick();
            check($sformatf("vec%0d_valid", i), 64'(dout_valid), 64'(tbl[i].exp_valid));
            if (tbl[i].chk_dout) check($sformatf("vec%0d_dout", i), dout, tbl[i].exp_dout);
        end

        // backpressure: three words, ready 1,0,0,...
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din_valid = 1'b1; din = mk_word(100 + i); expect_word(mk_word(100 + i));
            tick();
        end
        din_valid = 1'b0;
        drain(1, 200);

        // overflow: the output register absorbs word 0, so the FIFO holds 1..512 and 513 is dropped
        dout_ready = 1'b0;
        for (int i = 0; i < 514; i++) begin
            din_valid = 1'b1; din = mk_word(i);
            tick();
        end
        din_valid = 1'b0;
        check("ovf_valid_stalled", 64'(dout_valid), 64'd1);
        check("ovf_head_dout", dout, {32'd0, 32'd0});
        for (int i = 0; i <= 512; i++) expect_word(mk_word(i));
        drain(0, 3000);

        // reset mid-stream after two slices of a three-word burst
        dout_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din_valid = 1'b1; din = mk_word(200 + i);
            tick();
            if (i > 0) check($sformatf("burst_dout%0d", i), dout, {32'd200, 32'(i - 1)});
        end
        din_valid = 1'b0;
        tick();
        check("burst_dout3", dout, {32'd200, 32'd2});
        rst = 1'b1;
        tick();
        check("midrst_valid", 64'(dout_valid), 64'd0);
        check("midrst_dout", dout, 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_valid%0d", i), 64'(dout_valid), 64'd0);
        end
        din_valid = 1'b1; din = mk_word(300); expect_word(mk_word(300));
        tick();
        din_valid = 1'b0;
        drain(0, 50);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
